// File: rtl/video_pkg.sv
// Shared video constants, the packed draw-coordinate layout and the scan FSM states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package video_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int N_SPRITES = 4;
  localparam int INDEX_W   = 7;
  localparam int ADDR_W    = 15;

  // Matches the 16-bit draw coordinate bus: {Y[7:0], X[7:0]}.
  typedef struct packed {
    logic [7:0] y;
    logic [7:0] x;
  } coord_t;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    WRITE,
    DONE
  } scan_state_t;

endpackage

// File: rtl/sprite_priority_mux.sv
// First-nonzero selection over the sprite slots (slot 0 wins), else the background index.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
//
// Ports:
//   sprite_index  packed slot replies, slot k at [k*INDEX_W +: INDEX_W]
//   bg_index      fallback index when every slot is transparent (0)
//   index         resolved index
module sprite_priority_mux
  import video_pkg::*;
#(
  parameter int N_SPRITES = video_pkg::N_SPRITES,
  parameter int INDEX_W   = video_pkg::INDEX_W
) (
  input  logic [N_SPRITES*INDEX_W-1:0] sprite_index,
  input  logic [INDEX_W-1:0]           bg_index,
  output logic [INDEX_W-1:0]           index
);

  // Walk from the lowest-priority slot upward so the last hit written is slot 0's.
  always_comb begin
    index = bg_index;
    for (int k = N_SPRITES - 1; k >= 0; k--) begin
      if (sprite_index[k*INDEX_W +: INDEX_W] != '0) begin
        index = sprite_index[k*INDEX_W +: INDEX_W];
      end
    end
  end

endmodule

// File: rtl/sprite_scan_compositor.sv
// Raster-scans the screen, resolves sprite/background priority per pixel and writes the frame buffer.
// Latency: 2 cycles per pixel minimum (LOOKUP then WRITE); WR_EN rises 1 cycle after DRAW_COORD changes.
// Backpressure: WR_READY low stalls in WRITE with address, data and coordinate held; no timeout.
//
// Ports:
//   CLK, RESET (async, active-high), START (one-cycle frame request, honoured only when idle)
//   DRAW_COORD   {Y,X} being looked up by the sprite blocks
//   SPRITE_INDEX / BG_INDEX  combinational replies for DRAW_COORD
//   WR_EN / WR_ADDR / WR_DATA / WR_READY  frame buffer write port (valid/ready)
//   BUSY (frame in progress), FRAME_DONE (one-cycle end-of-frame pulse)
module sprite_scan_compositor
  import video_pkg::*;
#(
  parameter int SCREEN_W  = video_pkg::SCREEN_W,
  parameter int SCREEN_H  = video_pkg::SCREEN_H,
  parameter int N_SPRITES = video_pkg::N_SPRITES,
  parameter int INDEX_W   = video_pkg::INDEX_W,
  parameter int ADDR_W    = video_pkg::ADDR_W
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         START,
  output logic [15:0]                  DRAW_COORD,
  input  logic [N_SPRITES*INDEX_W-1:0] SPRITE_INDEX,
  input  logic [INDEX_W-1:0]           BG_INDEX,
  output logic                         WR_EN,
  output logic [ADDR_W-1:0]            WR_ADDR,
  output logic [INDEX_W-1:0]           WR_DATA,
  input  logic                         WR_READY,
  output logic                         BUSY,
  output logic                         FRAME_DONE
);

  scan_state_t        state;
  scan_state_t        state_next;
  coord_t             coord;
  logic [ADDR_W-1:0]  addr;
  logic [INDEX_W-1:0] mux_index;
  logic               x_last;
  logic               y_last;
  logic               handshake;

  sprite_priority_mux #(
    .N_SPRITES (N_SPRITES),
    .INDEX_W   (INDEX_W)
  ) u_prio (
    .sprite_index (SPRITE_INDEX),
    .bg_index     (BG_INDEX),
    .index        (mux_index)
  );

  assign x_last     = (coord.x == 8'(SCREEN_W - 1));
  assign y_last     = (coord.y == 8'(SCREEN_H - 1));
  assign handshake  = WR_EN & WR_READY;
  assign DRAW_COORD = coord;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (START) state_next = LOOKUP;
      LOOKUP:  state_next = WRITE;
      WRITE:   if (handshake) state_next = (x_last && y_last) ? DONE : LOOKUP;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counters and the registered write port. The address is a running counter
  // that tracks Y*SCREEN_W+X, so no multiplier is needed.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      coord      <= '0;
      addr       <= '0;
      WR_EN      <= 1'b0;
      WR_ADDR    <= '0;
      WR_DATA    <= '0;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            coord <= '0;
            addr  <= '0;
            BUSY  <= 1'b1;
          end
        end
        LOOKUP: begin
          WR_DATA <= mux_index;
          WR_ADDR <= addr;
          WR_EN   <= 1'b1;
        end
        WRITE: begin
          if (handshake) begin
            WR_EN <= 1'b0;
            if (x_last && y_last) begin
              // Coordinate is left on the last pixel until the next frame.
              FRAME_DONE <= 1'b1;
            end else begin
              if (x_last) begin
                coord.x <= '0;
                coord.y <= coord.y + 8'd1;
              end else begin
                coord.x <= coord.x + 8'd1;
              end
              addr <= addr + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          BUSY <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sprite_scan_compositor.md
Name: sprite_scan_compositor

Overview:
- Coordinate-issuing end of the sprite lookup interface. Walks every screen pixel in raster order and drives a packed {Y,X} draw coordinate onto all sprite blocks.
- Samples their combinational index replies, resolves priority against the background index, and writes the winning 7-bit tile index into the frame buffer through a valid/ready write port.
- Sits between the sprite blocks (hero, enemies) and the frame buffer; started once per frame by the frame-sync logic.

Parameters:
- SCREEN_W, 160, pixels per row; X range 0..SCREEN_W-1, X ≤ 255.
- SCREEN_H, 120, rows per frame; Y range 0..SCREEN_H-1, Y ≤ 255.
- N_SPRITES, 4, number of sprite index inputs; slot 0 has the highest priority.
- INDEX_W, 7, tile index width; index 0 means transparent / no hit.
- ADDR_W, 15, frame buffer address width; must satisfy 2^ADDR_W ≥ SCREEN_W*SCREEN_H.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  single-cycle frame start request.
- DRAW_COORD  out  16  {Y[7:0], X[7:0]} coordinate currently under lookup.
- SPRITE_INDEX  in  N_SPRITES*INDEX_W  sprite replies; slot k is bits [k*INDEX_W +: INDEX_W]; combinational on DRAW_COORD.
- BG_INDEX  in  INDEX_W  background index for DRAW_COORD; combinational.
- WR_EN  out  1  write valid.
- WR_ADDR  out  ADDR_W  linear address, Y*SCREEN_W+X.
- WR_DATA  out  INDEX_W  composited index.
- WR_READY  in  1  frame buffer accepts the write on a cycle when WR_EN and WR_READY are both high.
- BUSY  out  1  high from the cycle after START is accepted until FRAME_DONE.
- FRAME_DONE  out  1  one-cycle pulse after the last pixel's write is accepted.

Behaviour:
- Reset values: state IDLE; DRAW_COORD=0, WR_EN=0, WR_ADDR=0, WR_DATA=0, BUSY=0, FRAME_DONE=0; internal X, Y and address counters cleared.
- FSM states: IDLE, LOOKUP, WRITE, DONE.
- IDLE:
  - On START=1, clear X, Y and address to 0 and go to LOOKUP.
  - START is ignored in every other state.
- LOOKUP (1 cycle):
  - DRAW_COORD={Y,X} has been stable since entry.
  - At the clock edge, register WR_DATA = first nonzero SPRITE_INDEX slot in order 0..N_SPRITES-1; if no slot is nonzero, WR_DATA = BG_INDEX.
  - Register WR_ADDR = address counter, set WR_EN=1, go to WRITE.
- WRITE:
  - WR_EN, WR_ADDR, WR_DATA and DRAW_COORD are held stable while WR_READY=0; there is no timeout.
  - On handshake (WR_EN & WR_READY), WR_EN drops to 0 in the next cycle.
  - If X==SCREEN_W-1 and Y==SCREEN_H-1, go to DONE.
  - Else if X==SCREEN_W-1: X←0, Y←Y+1. Otherwise X←X+1. In both cases address←address+1 and go to LOOKUP.
- DONE (1 cycle): FRAME_DONE=1, BUSY=0 next cycle, go to IDLE. DRAW_COORD keeps the last pixel value until the next START.
- Throughput and latency:
  - Minimum 2 cycles per pixel; a full frame with WR_READY tied high takes exactly 2*SCREEN_W*SCREEN_H cycles from LOOKUP entry to DONE.
  - Latency from DRAW_COORD change to WR_EN rising: 1 cycle.
- The address is a running counter, never a multiply. Wrap-around of X and Y past the limits is impossible by construction.
- START arriving in the same cycle as DONE is ignored; the frame-sync logic re-issues it.
- RESET mid-frame: immediate return to IDLE with all outputs at their reset values. Any pending write is dropped without completing.

Decomposition:
- Shared package (video_pkg) holds:
  - SCREEN_W, SCREEN_H, INDEX_W, ADDR_W constants.
  - A coord_t packed struct {y[7:0], x[7:0]} matching the 16-bit draw coordinate packing.
  - The scan_state_t enum.
- One sub-module, sprite_priority_mux: purely combinational first-nonzero selection over N_SPRITES slots, falling back to BG_INDEX. It is reused later by the sprite collision logic.

Test Plan:
- Hero stub at (20,20) returning 1 inside its 16x16 box, BG_INDEX=5, WR_READY=1, START pulse → writes addr 3220 data 1; addr 5635 (35,35) data 1; addr 3236 (36,20) data 5; addr 3219 data 5.
- Full frame with WR_READY=1 → exactly 19200 writes with addresses 0..19199 strictly increasing. Last DRAW_COORD=0x779F. FRAME_DONE pulses once, 38400 cycles after LOOKUP entry.
- Backpressure: WR_READY held low 3 cycles at addr 161 → WR_EN, WR_ADDR=161, WR_DATA and DRAW_COORD=0x0101 all constant for those cycles. Exactly one write is accepted.
- Priority: slot 0=3 and slot 2=9 both active at (50,40) → data 3 at addr 6450. Slot 0=0, slot 2=9 → data 9.
- RESET asserted mid-frame at addr 1000 → outputs zero asynchronously, BUSY=0. A new START restarts at addr 0.
- START pulsed while BUSY → no restart; address sequence continues unbroken and only one FRAME_DONE occurs.
